serial_cmd_initiator: RTL and testbench

// Host-side initiator for the board's one-byte-opcode serial command protocol. Accepts one

---
 rtl/serial_cmd_initiator.sv | 199 +++++++++++++++++++
 tb/tb_serial_cmd_initiator.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_cmd_initiator.sv
// Host-side initiator for the one-byte-opcode serial command protocol: sends opcode plus
// argument bytes to a UART transmitter and streams the fixed-length response back out.
module serial_cmd_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned MAX_OPCODE     = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_opcode,
    input  logic [47:0] cmd_args,
    input  logic        txBusy,
    output logic        txStart,
    output logic [7:0]  txData,
    input  logic        rxReady,
    input  logic [7:0]  rxData,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic [7:0]  rsp_index,
    output logic        done,
    output logic [1:0]  error,
    output logic        busy
);

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StTxByte,
        StTxGap,
        StTxDrain,
        StRxCollect
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [47:0] args_q, args_d;
    logic [2:0]  tx_cnt_q, tx_cnt_d;
    logic [2:0]  n_tx_q, n_tx_d;
    logic [7:0]  n_rx_q, n_rx_d;
    logic [7:0]  rx_cnt_q, rx_cnt_d;
    logic [31:0] timer_q, timer_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic [7:0]  rsp_index_q, rsp_index_d;
    logic        done_q, done_d;
    logic [1:0]  error_q, error_d;

    function automatic logic [2:0] arg_count(input logic [2:0] op);
        case (op)
            3'd1, 3'd3, 3'd5, 3'd7: arg_count = 3'd1;
            3'd2:                   arg_count = 3'd6;
            default:                arg_count = 3'd0;
        endcase
    endfunction

    function automatic logic [7:0] rsp_count(input logic [2:0] op);
        case (op)
            3'd0:    rsp_count = 8'd1;
            3'd4:    rsp_count = 8'd136;
            default: rsp_count = 8'd0;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        args_d      = args_q;
        tx_cnt_d    = tx_cnt_q;
        n_tx_d      = n_tx_q;
        n_rx_d      = n_rx_q;
        rx_cnt_d    = rx_cnt_q;
        timer_d     = timer_q;
        tx_data_d   = tx_data_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_index_d = rsp_index_q;
        done_d      = 1'b0;
        error_d     = error_q;
        txStart     = 1'b0;

        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    opcode_d = cmd_opcode;
                    args_d   = cmd_args;
                    error_d  = 2'b00;
                    tx_cnt_d = 3'd0;
                    state_d  = StLookup;
                end
            end
            StLookup: begin
                if (opcode_q > 8'(MAX_OPCODE)) begin
                    error_d = 2'b01;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    n_tx_d    = 3'd1 + arg_count(opcode_q[2:0]);
                    n_rx_d    = rsp_count(opcode_q[2:0]);
                    tx_data_d = opcode_q;
                    state_d   = StTxByte;
                end
            end
            StTxByte: begin
                // txData already holds byte[tx_cnt]; the start strobe is the only action here.
                if (!txBusy) begin
                    txStart = 1'b1;
                    state_d = StTxGap;
                end
            end
            StTxGap: begin
                if (tx_cnt_q + 3'd1 < n_tx_q) begin
                    tx_cnt_d  = tx_cnt_q + 3'd1;
                    tx_data_d = args_q[{tx_cnt_q, 3'b000} +: 8];
                    state_d   = StTxByte;
                end else if (n_rx_q == 8'd0) begin
                    state_d = StTxDrain;
                end else begin
                    rx_cnt_d = 8'd0;
                    timer_d  = 32'd0;
                    state_d  = StRxCollect;
                end
            end
            StTxDrain: begin
                if (!txBusy) begin
                    done_d  = 1'b1;
                    error_d = 2'b00;
                    state_d = StIdle;
                end
            end
            StRxCollect: begin
                // A byte arriving on the expiry cycle takes priority over the timeout.
                if (rx_cnt_q == n_rx_q) begin
                    done_d  = 1'b1;
                    error_d = 2'b00;
                    state_d = StIdle;
                end else if (rxReady) begin
                    rsp_data_d  = rxData;
                    rsp_index_d = rx_cnt_q;
                    rsp_valid_d = 1'b1;
                    rx_cnt_d    = rx_cnt_q + 8'd1;
                    timer_d     = 32'd0;
                end else if (timer_q == TIMEOUT_CYCLES - 1) begin
                    error_d = 2'b10;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            opcode_q    <= 8'd0;
            args_q      <= 48'd0;
            tx_cnt_q    <= 3'd0;
            n_tx_q      <= 3'd0;
            n_rx_q      <= 8'd0;
            rx_cnt_q    <= 8'd0;
            timer_q     <= 32'd0;
            tx_data_q   <= 8'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'd0;
            rsp_index_q <= 8'd0;
            done_q      <= 1'b0;
            error_q     <= 2'b00;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            args_q      <= args_d;
            tx_cnt_q    <= tx_cnt_d;
            n_tx_q      <= n_tx_d;
            n_rx_q      <= n_rx_d;
            rx_cnt_q    <= rx_cnt_d;
            timer_q     <= timer_d;
            tx_data_q   <= tx_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_index_q <= rsp_index_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign txData    = tx_data_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_index = rsp_index_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_serial_cmd_initiator.sv
// Scoreboard bench for serial_cmd_initiator: stimulus pushes expected tx bytes, response
// bytes and done/error outcomes; a negedge monitor pops and compares as the DUT emits them.
module tb_serial_cmd_initiator;

    localparam int unsigned TO = 100;

    typedef struct packed {
        logic [1:0]  err;
        logic [1:0]  kind;   // 0: no latency check, 1: from accept, 2: from last rsp_valid
        logic [15:0] delta;
    } done_exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_opcode;
    logic [47:0] cmd_args;
    logic        txBusy;
    logic        txStart;
    logic [7:0]  txData;
    logic        rxReady;
    logic [7:0]  rxData;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic [7:0]  rsp_index;
    logic        done;
    logic [1:0]  error;
    logic        busy;

    serial_cmd_initiator #(
        .TIMEOUT_CYCLES(TO),
        .MAX_OPCODE    (7)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_opcode(cmd_opcode),
        .cmd_args  (cmd_args),
        .txBusy    (txBusy),
        .txStart   (txStart),
        .txData    (txData),
        .rxReady   (rxReady),
        .rxData    (rxData),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_index (rsp_index),
        .done      (done),
        .error     (error),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  exp_tx[$];
    logic [15:0] exp_rsp[$];
    done_exp_t   exp_done[$];
    int          tx_seen = 0;
    int          accept_cyc = 0;
    int          last_rsp_cyc = 0;
    bit          first_tx_pending = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
    endtask

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                if (cmd_valid && cmd_ready) begin
                    accept_cyc       = cyc;
                    first_tx_pending = 1'b1;
                end
                if (txStart) begin
                    tx_seen++;
                    if (exp_tx.size() == 0) fail("tx_unexpected");
                    else chk("tx_byte", 32'(txData), 32'(exp_tx.pop_front()));
                    if (first_tx_pending) begin
                        chk("tx_latency", 32'(cyc - accept_cyc), 32'd2);
                        first_tx_pending = 1'b0;
                    end
                end
                if (rsp_valid) begin
                    last_rsp_cyc = cyc;
                    if (exp_rsp.size() == 0) fail("rsp_unexpected");
                    else chk("rsp_data_index", 32'({rsp_data, rsp_index}),
                             32'(exp_rsp.pop_front()));
                end
                if (done) begin
                    if (exp_done.size() == 0) begin
                        fail("done_unexpected");
                    end else begin
                        done_exp_t e;
                        e = exp_done.pop_front();
                        chk("done_error", 32'(error), 32'(e.err));
                        if (e.kind == 2'd1)
                            chk("done_lat_accept", 32'(cyc - accept_cyc), 32'(e.delta));
                        else if (e.kind == 2'd2)
                            chk("done_lat_rsp", 32'(cyc - last_rsp_cyc), 32'(e.delta));
                    end
                end
            end
        end
    end

    // UART transmitter model: busy rises the cycle after txStart, stays up 3 cycles.
    initial begin
        txBusy = 1'b0;
        forever begin
            @(negedge clk);
            if (txStart && reset !== 1'b1) begin
                @(posedge clk);
                #1 txBusy = 1'b1;
                repeat (3) @(posedge clk);
                #1 txBusy = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [47:0] args);
        int w = 0;
        while (!cmd_ready && w < 200) begin
            tick(1);
            w++;
        end
        if (!cmd_ready) fail("cmd_ready_wait");
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_args   = args;
        tick(1);
        cmd_valid  = 1'b0;
    endtask

    task automatic wait_tx(input int target);
        int w = 0;
        while (tx_seen < target && w < 500) begin
            tick(1);
            w++;
        end
        if (tx_seen < target) fail("tx_wait");
    endtask

    task automatic wait_done();
        int w = 0;
        while (exp_done.size() != 0 && w < 2000) begin
            tick(1);
            w++;
        end
        if (exp_done.size() != 0) fail("done_wait");
        tick(2);
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rxReady = 1'b1;
        rxData  = b;
        tick(1);
        rxReady = 1'b0;
    endtask

    task automatic push_done(input logic [1:0] err, input logic [1:0] kind, input int delta);
        done_exp_t e;
        e.err   = err;
        e.kind  = kind;
        e.delta = 16'(delta);
        exp_done.push_back(e);
    endtask

    initial begin
        logic [7:0]  bad_ops[3];
        logic [47:0] args2;
        int          base;
        int          w;

        reset      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_opcode = 8'd0;
        cmd_args   = 48'd0;
        rxReady    = 1'b0;
        rxData     = 8'd0;
        #1 reset = 1'b1;
        tick(2);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_txstart", 32'(txStart), 32'd0);
        chk("rst_txdata", 32'(txData), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_index", 32'(rsp_index), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        reset = 1'b0;
        tick(2);

        // Opcode 0: one tx byte, one response byte
        base = tx_seen;
        exp_tx.push_back(8'h00);
        exp_rsp.push_back({8'h17, 8'd0});
        push_done(2'b00, 2'd2, 1);
        send_cmd(8'h00, 48'd0);
        wait_tx(base + 1);
        tick(3);
        rx_byte(8'h17);
        wait_done();

        // Opcode 2: seven tx bytes, no response; stray rxReady and cmd_valid while busy
        args2 = 48'h06_05_04_03_02_01;
        base  = tx_seen;
        exp_tx.push_back(8'h02);
        for (int i = 1; i <= 6; i++) exp_tx.push_back(8'(i));
        push_done(2'b00, 2'd0, 0);
        send_cmd(8'h02, args2);
        wait_tx(base + 2);
        rx_byte(8'hEE);
        cmd_valid  = 1'b1;
        cmd_opcode = 8'h00;
        tick(1);
        cmd_valid  = 1'b0;
        wait_done();
        chk("op2_tx_count", 32'(tx_seen - base), 32'd7);

        // Opcode 4: 136-byte response, mixed inter-byte gaps
        base = tx_seen;
        exp_tx.push_back(8'h04);
        for (int i = 0; i < 136; i++) exp_rsp.push_back({8'(i), 8'(i)});
        push_done(2'b00, 2'd2, 1);
        send_cmd(8'h04, 48'd0);
        wait_tx(base + 1);
        tick(3);
        for (int i = 0; i < 136; i++) begin
            rx_byte(8'(i));
            tick(i % 3);
        end
        wait_done();

        // Rejected opcodes: done two cycles after accept, nothing transmitted
        bad_ops[0] = 8'h08;
        bad_ops[1] = 8'h09;
        bad_ops[2] = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            push_done(2'b01, 2'd1, 2);
            send_cmd(bad_ops[k], 48'hFFFF_FFFF_FFFF);
            wait_done();
            chk("bad_err_held", 32'(error), 32'd1);
        end

        // Timeout: opcode 4, response stops after 10 bytes
        base = tx_seen;
        exp_tx.push_back(8'h04);
        for (int i = 0; i < 10; i++) exp_rsp.push_back({8'(i), 8'(i)});
        push_done(2'b10, 2'd2, TO);
        send_cmd(8'h04, 48'd0);
        wait_tx(base + 1);
        tick(3);
        for (int i = 0; i < 10; i++) begin
            rx_byte(8'(i));
            tick(1);
        end
        wait_done();
        chk("timeout_err_held", 32'(error), 32'd2);

        // Reset after the third tx byte, landing as the fourth start strobe appears
        base = tx_seen;
        exp_tx.push_back(8'h02);
        for (int i = 1; i <= 6; i++) exp_tx.push_back(8'hA0 + 8'(i));
        push_done(2'b00, 2'd0, 0);
        send_cmd(8'h02, 48'hA6_A5_A4_A3_A2_A1);
        wait_tx(base + 3);
        w = 0;
        while (txStart !== 1'b1 && w < 50) begin
            tick(1);
            w++;
        end
        if (txStart !== 1'b1) fail("fourth_txstart_wait");
        reset = 1'b1;
        #1;
        chk("midrst_txstart", 32'(txStart), 32'd0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        exp_tx.delete();
        exp_rsp.delete();
        exp_done.delete();
        tick(2);
        reset = 1'b0;
        tick(1);

        base = tx_seen;
        exp_tx.push_back(8'h00);
        exp_rsp.push_back({8'h5A, 8'd0});
        push_done(2'b00, 2'd2, 1);
        send_cmd(8'h00, 48'd0);
        wait_tx(base + 1);
        tick(3);
        rx_byte(8'h5A);
        wait_done();

        chk("tx_queue_left", 32'(exp_tx.size()), 32'd0);
        chk("rsp_queue_left", 32'(exp_rsp.size()), 32'd0);
        chk("done_queue_left", 32'(exp_done.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
